// File: rtl/ucode_loader_if.sv
// ucode_loader_if: byte stream into the loader plus the sequencer ROM-write port.
// The slave modport is the loader side: it sinks the stream and drives the ROM write.
// The master modport is the host/ROM side.
interface ucode_loader_if #(
  parameter int ADDR_W = 8
);
  logic              s_valid;
  logic              s_ready;
  logic [7:0]        s_data;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_waddr;
  logic [15:0]       rom_wdata;

  modport slave (
    input  s_valid, s_data,
    output s_ready, rom_we, rom_waddr, rom_wdata
  );

  modport master (
    output s_valid, s_data,
    input  s_ready, rom_we, rom_waddr, rom_wdata
  );
endinterface

// File: rtl/ucode_loader.sv
// ucode_loader: assembles a framed byte stream (N, N x {lo,hi}, XOR checksum)
// into 16-bit instructions written to consecutive sequencer ROM addresses.
// Optional feature macro AUTO_START_EN: after a good checksum wait for the
// sequencer to be idle and pulse seq_start_o once.
module ucode_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  ucode_loader_if.slave         bus,
  input  logic                  abort_i,
  input  logic                  seq_ready_i,
  output logic                  seq_start_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LO,
    ST_HI,
`ifdef AUTO_START_EN
    ST_START,
`endif
    ST_CHK
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        n_q, n_d;
  logic [7:0]        idx_q, idx_d;
  logic [7:0]        lo_q, lo_d;
  logic [7:0]        chk_q, chk_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              start_q, start_d;
  logic              s_ready;
  logic              accept;

  assign accept      = bus.s_valid & s_ready;
  assign bus.s_ready = s_ready;
  assign bus.rom_we    = we_q;
  assign bus.rom_waddr = waddr_q;
  assign bus.rom_wdata = wdata_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
`ifdef AUTO_START_EN
  assign seq_start_o = start_q;
`else
  assign seq_start_o = 1'b0;
`endif

  // Next-state, handshake and write/flag decode; abort overrides everything else.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    lo_d    = lo_q;
    chk_d   = chk_q;
    err_d   = err_q;
    done_d  = 1'b0;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    start_d = 1'b0;
    s_ready = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Gated by reset so the stream sees s_ready=0 while held in reset.
        s_ready = seq_ready_i & rst_n_i;
        if (accept) begin
          n_d     = bus.s_data;
          err_d   = 1'b0;
          chk_d   = bus.s_data;
          idx_d   = 8'd0;
          state_d = (bus.s_data != 8'd0) ? ST_LO : ST_CHK;
        end
      end
      ST_LO: begin
        s_ready = 1'b1;
        if (accept) begin
          lo_d    = bus.s_data;
          chk_d   = chk_q ^ bus.s_data;
          state_d = ST_HI;
        end
      end
      ST_HI: begin
        s_ready = 1'b1;
        if (accept) begin
          chk_d   = chk_q ^ bus.s_data;
          we_d    = 1'b1;
          wdata_d = {bus.s_data, lo_q};
          waddr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q);
          idx_d   = idx_q + 8'd1;
          state_d = (({1'b0, idx_q} + 9'd1) < {1'b0, n_q}) ? ST_LO : ST_CHK;
        end
      end
      ST_CHK: begin
        s_ready = 1'b1;
        if (accept) begin
          done_d = 1'b1;
          if (bus.s_data != chk_q) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
`ifdef AUTO_START_EN
            state_d = ST_START;
`else
            state_d = ST_IDLE;
`endif
          end
        end
      end
`ifdef AUTO_START_EN
      ST_START: begin
        if (seq_ready_i) begin
          start_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // A byte accepted alongside abort is consumed but has no effect.
    if (abort_i && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
      done_d  = 1'b0;
      we_d    = 1'b0;
      start_d = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      n_q     <= 8'd0;
      idx_q   <= 8'd0;
      lo_q    <= 8'd0;
      chk_q   <= 8'd0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= ADDR_W'(BASE_ADDR);
      wdata_q <= 16'd0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
      chk_q   <= chk_d;
      err_q   <= err_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      start_q <= start_d;
    end
  end

endmodule

// File: tb/tb_ucode_loader.sv
// tb_ucode_loader: table-driven frame vectors plus hand sequences for
// handshake gating, abort, reset mid-frame and (AUTO_START_EN) start wait.
// Two loaders share the stream: BASE_ADDR=0 and BASE_ADDR=0xFF (wrap).
module tb_ucode_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       abort = 1'b0;
  logic       seq_ready = 1'b1;

  ucode_loader_if #(.ADDR_W(8)) if0 ();
  ucode_loader_if #(.ADDR_W(8)) if1 ();
  assign if0.s_valid = s_valid;
  assign if0.s_data  = s_data;
  assign if1.s_valid = s_valid;
  assign if1.s_data  = s_data;

  logic start0, start1, busy0, busy1, done0, done1, err0, err1;

  ucode_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .bus(if0), .abort_i(abort),
    .seq_ready_i(seq_ready), .seq_start_o(start0), .busy_o(busy0),
    .done_o(done0), .err_o(err0));

  ucode_loader #(.ADDR_W(8), .BASE_ADDR(255)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .bus(if1), .abort_i(abort),
    .seq_ready_i(seq_ready), .seq_start_o(start1), .busy_o(busy1),
    .done_o(done1), .err_o(err1));

  int total = 0;
  int bad = 0;

  // Write / pulse monitor, sampled on the falling edge.
  logic [7:0]  wa0 [$];
  logic [15:0] wd0 [$];
  logic [7:0]  wa1 [$];
  logic [15:0] wd1 [$];
  int done_cnt = 0;
  int start_cnt = 0;

  always @(negedge clk) begin
    if (if0.rom_we) begin
      wa0.push_back(if0.rom_waddr);
      wd0.push_back(if0.rom_wdata);
    end
    if (if1.rom_we) begin
      wa1.push_back(if1.rom_waddr);
      wd1.push_back(if1.rom_wdata);
    end
    if (done0) done_cnt++;
    if (start0) start_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    wa0.delete(); wd0.delete(); wa1.delete(); wd1.delete();
    done_cnt = 0;
    start_cnt = 0;
  endtask

  // Present one byte at a falling edge and hold it until accepted.
  task automatic send(input logic [7:0] b, input int gap);
    int w;
    repeat (gap) begin s_valid = 1'b0; @(negedge clk); end
    s_valid = 1'b1;
    s_data  = b;
    w = 0;
    while (!if0.s_ready && w < 50) begin @(negedge clk); w++; end
    if (w >= 50) check("send_timeout", 32'd1, 32'd0);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  function automatic int exp_start(input logic e);
`ifdef AUTO_START_EN
    return e ? 0 : 1;
`else
    return 0;
`endif
  endfunction

  typedef struct {
    string       name;
    int          len;
    logic [7:0]  b [6];
    int          gap;
    int          nwr;
    logic [15:0] wd [2];
    logic        exp_err;
  } vec_t;

  vec_t v [5];

  task automatic run_vec(input vec_t t);
    repeat (3) @(negedge clk);
    clear_mon();
    for (int i = 0; i < t.len; i++)
      send(t.b[i], (t.gap != 0) ? int'($urandom_range(0, 3)) : 0);
    repeat (5) @(negedge clk);
    check({t.name, "_nwr"}, wa0.size(), t.nwr);
    check({t.name, "_nwr1"}, wa1.size(), t.nwr);
    for (int i = 0; i < t.nwr && i < wa0.size() && i < wa1.size(); i++) begin
      check({t.name, "_addr0"}, wa0[i], i);
      check({t.name, "_data0"}, wd0[i], t.wd[i]);
      check({t.name, "_addr1"}, wa1[i], (i + 255) % 256);
      check({t.name, "_data1"}, wd1[i], t.wd[i]);
    end
    check({t.name, "_done"}, done_cnt, 1);
    check({t.name, "_err"}, err0, t.exp_err);
    check({t.name, "_err1"}, err1, t.exp_err);
    check({t.name, "_start"}, start_cnt, exp_start(t.exp_err));
    check({t.name, "_busy"}, busy0, 1'b0);
  endtask

  initial begin
    v[0].name = "good2";  v[0].len = 6; v[0].gap = 0; v[0].nwr = 2; v[0].exp_err = 1'b0;
    v[0].b = '{8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h0A};
    v[0].wd = '{16'h3412, 16'h7856};
    v[1].name = "badchk"; v[1].len = 6; v[1].gap = 0; v[1].nwr = 2; v[1].exp_err = 1'b1;
    v[1].b = '{8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h0B};
    v[1].wd = '{16'h3412, 16'h7856};
    v[2].name = "empty";  v[2].len = 2; v[2].gap = 0; v[2].nwr = 0; v[2].exp_err = 1'b0;
    v[2].b = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    v[2].wd = '{16'h0000, 16'h0000};
    v[3].name = "gaps";   v[3].len = 6; v[3].gap = 1; v[3].nwr = 2; v[3].exp_err = 1'b0;
    v[3].b = '{8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h0A};
    v[3].wd = '{16'h3412, 16'h7856};
    v[4].name = "one";    v[4].len = 4; v[4].gap = 0; v[4].nwr = 1; v[4].exp_err = 1'b0;
    v[4].b = '{8'h01, 8'hAA, 8'hBB, 8'h10, 8'h00, 8'h00};
    v[4].wd = '{16'hBBAA, 16'h0000};

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_s_ready", if0.s_ready, 1'b0);
    check("rst_rom_we", if0.rom_we, 1'b0);
    check("rst_waddr0", if0.rom_waddr, 8'h00);
    check("rst_waddr1", if1.rom_waddr, 8'hFF);
    check("rst_wdata", if0.rom_wdata, 16'h0000);
    check("rst_flags", {start0, busy0, done0, err0}, 4'b0000);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (v[i]) run_vec(v[i]);

    // seq_ready low in IDLE blocks the count byte.
    repeat (3) @(negedge clk);
    clear_mon();
    seq_ready = 1'b0;
    s_valid = 1'b1;
    s_data = 8'h02;
    @(negedge clk);
    check("gate_s_ready", if0.s_ready, 1'b0);
    repeat (3) @(negedge clk);
    check("gate_busy", busy0, 1'b0);
    seq_ready = 1'b1;
    #1;
    check("gate_s_ready_up", if0.s_ready, 1'b1);
    @(negedge clk);
    s_valid = 1'b0;
    check("gate_busy_up", busy0, 1'b1);
    send(8'h12, 0); send(8'h34, 0); send(8'h56, 0); send(8'h78, 0); send(8'h0A, 0);
    repeat (5) @(negedge clk);
    check("gate_nwr", wa0.size(), 2);
    check("gate_done", done_cnt, 1);
    check("gate_err", err0, 1'b0);

    // Abort with only a lo byte pending.
    repeat (3) @(negedge clk);
    clear_mon();
    send(8'h01, 0); send(8'hAA, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy0, 1'b0);
    check("abort_err", err0, 1'b1);
    repeat (3) @(negedge clk);
    check("abort_nwr", wa0.size(), 0);
    check("abort_done", done_cnt, 0);
    run_vec(v[0]);

    // Abort in the same cycle as the hi byte: byte discarded, no write.
    repeat (3) @(negedge clk);
    clear_mon();
    send(8'h01, 0); send(8'hAA, 0);
    s_valid = 1'b1; s_data = 8'hBB; abort = 1'b1;
    @(negedge clk);
    s_valid = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    check("abhi_nwr", wa0.size(), 0);
    check("abhi_err", err0, 1'b1);
    check("abhi_busy", busy0, 1'b0);
    check("abhi_done", done_cnt, 0);

    // Reset mid-frame while the hi byte is offered.
    run_vec(v[4]);
    repeat (3) @(negedge clk);
    clear_mon();
    send(8'h01, 0); send(8'hAA, 0);
    s_valid = 1'b1; s_data = 8'hBB; rst_n = 1'b0;
    @(negedge clk);
    s_valid = 1'b0;
    check("rstmid_we", if0.rom_we, 1'b0);
    check("rstmid_busy", busy0, 1'b0);
    check("rstmid_waddr", if0.rom_waddr, 8'h00);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rstmid_nwr", wa0.size(), 0);

`ifdef AUTO_START_EN
    // START waits for seq_ready before pulsing.
    repeat (3) @(negedge clk);
    clear_mon();
    send(8'h00, 0);
    seq_ready = 1'b0;
    send(8'h00, 0);
    repeat (3) @(negedge clk);
    check("wait_start_none", start_cnt, 0);
    check("wait_busy", busy0, 1'b1);
    seq_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("wait_start_one", start_cnt, 1);
    check("wait_busy_low", busy0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
